// File: rtl/cpu_fetch_queue.sv
// Prefetching instruction fetch front end with a DEPTH-entry {pc, instr} queue.
// Define FETCHQ_BYPASS_EN to forward a response straight to o_ir when empty.
module cpu_fetch_queue #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] o_pc_addr,
  output logic              o_pc_rd,
  input  logic [DATA_W-1:0] i_pc_rddata,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_ir_valid,
  input  logic              i_ir_ready,
  output logic [DATA_W-1:0] o_ir,
  output logic [ADDR_W-1:0] o_ir_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic              inflight;
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [DATA_W-1:0] q_ir [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic              issue;
  logic              push;
  logic              pop_q;
  logic              q_nempty;

  // In-flight read reserves a slot so a response never overflows
  assign occ      = {1'b0, count} + (CW+1)'(inflight);
  assign issue    = reset && !i_redirect
                 && (occ < (CW+1)'(DEPTH));
  assign q_nempty = (count != '0);
  assign pop_q    = q_nempty && i_ir_ready && !i_redirect;

  assign o_pc_addr = fetch_pc;
  assign o_pc_rd   = issue;
  assign o_count   = count;

`ifdef FETCHQ_BYPASS_EN
  logic byp;

  assign byp        = inflight && !q_nempty && !i_redirect;
  assign push       = inflight && !i_redirect
                   && !(byp && i_ir_ready);
  assign o_ir_valid = (q_nempty && !i_redirect) || byp;
  assign o_ir       = byp ? i_pc_rddata : q_ir[rd_ptr];
  assign o_ir_pc    = byp ? resp_pc : q_pc[rd_ptr];
`else
  assign push       = inflight && !i_redirect;
  assign o_ir_valid = q_nempty && !i_redirect;
  assign o_ir       = q_ir[rd_ptr];
  assign o_ir_pc    = q_pc[rd_ptr];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i] <= '0;
        q_ir[i] <= '0;
      end
    end else if (i_redirect) begin
      fetch_pc <= i_redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        resp_pc  <= fetch_pc;
      end
      if (push) begin
        q_pc[wr_ptr] <= resp_pc;
        q_ir[wr_ptr] <= i_pc_rddata;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop_q) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop_q);
    end
  end

endmodule
